// File: rtl/mem_pkg.sv
// Shared types for the RV32I data memory: load/store funct3 encodings,
// responder FSM states and the funct3 legality check.
package mem_pkg;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd4,
      LHU = 3'd5
   } load_f3_t;

   typedef enum logic [2:0] {
      SB = 3'd0,
      SH = 3'd1,
      SW = 3'd2
   } store_f3_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // funct3 values with no RV32I meaning for the given direction
   function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
      if (write) return (f3 > 3'd2);
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response channel between the CPU load/store unit (master)
// and the data memory (slave).
interface data_memory_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering for the data memory: byte enables and replicated
// store data, load extraction with sign/zero extension, and the
// misalignment flag. Purely combinational, little-endian.
module load_store_align
   import mem_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   logic [31:0] rshift;

   // Move the addressed byte/half down to bit 0 of the word
   assign rshift = rword_i >> {off_i, 3'b000};

   // Access size comes from funct3[1:0] for both loads and stores
   always_comb begin
      be_o         = 4'b0000;
      wdata_o      = 32'h0;
      misaligned_o = 1'b0;
      case (funct3_i[1:0])
         2'd0: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'd1: begin
            be_o         = 4'b0011 << off_i;
            wdata_o      = {2{wdata_i[15:0]}};
            misaligned_o = off_i[0];
         end
         2'd2: begin
            be_o         = 4'b1111;
            wdata_o      = wdata_i;
            misaligned_o = (off_i != 2'd0);
         end
         default: ;
      endcase
   end

   // Load result extension
   always_comb begin
      rdata_o = 32'h0;
      case (funct3_i)
         LB:      rdata_o = {{24{rshift[7]}}, rshift[7:0]};
         LH:      rdata_o = {{16{rshift[15]}}, rshift[15:0]};
         LW:      rdata_o = rword_i;
         LBU:     rdata_o = {24'h0, rshift[7:0]};
         LHU:     rdata_o = {16'h0, rshift[15:0]};
         default: rdata_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// RV32I data memory responder. One request at a time, response after
// WAIT_CYCLES extra cycles, held until the CPU takes it.
// Optional macro DATA_MEMORY_STATS_EN adds saturating 16-bit counters
// stat_loads / stat_stores / stat_errors.
module data_memory
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset,
   data_memory_if.slave  bus
`ifdef DATA_MEMORY_STATS_EN
   ,
   output logic [15:0]   stat_loads,
   output logic [15:0]   stat_stores,
   output logic [15:0]   stat_errors
`endif
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   dmem_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rword, wdata_sh, rdata_ext;
   logic [3:0]  be;
   logic        misaligned, range_err, err, access, mem_we;

   assign rword     = mem_q[addr_q[AW+1:2]];
   assign range_err = (addr_q[31:2] >= 30'(DEPTH_WORDS));
   assign err       = misaligned | range_err | f3_illegal(write_q, funct3_q);
   assign access    = (state_q == WAIT) && (cnt_q == '0);
   // Gating on reset makes a reset that lands on the access edge abort the store
   assign mem_we    = access && !err && write_q && !reset;

   load_store_align u_align (
      .off_i        (addr_q[1:0]),
      .funct3_i     (funct3_q),
      .wdata_i      (wdata_q),
      .rword_i      (rword),
      .be_o         (be),
      .wdata_o      (wdata_sh),
      .rdata_o      (rdata_ext),
      .misaligned_o (misaligned)
   );

   assign bus.req_ready  = (state_q == IDLE) && !reset;
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_error = error_q;

   // Next state, request latch and response registers
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      rdata_d  = rdata_q;
      error_d  = error_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            write_d  = bus.req_write;
            addr_d   = bus.req_addr;
            wdata_d  = bus.req_wdata;
            funct3_d = bus.req_funct3;
            cnt_d    = CW'(WAIT_CYCLES);
            state_d  = WAIT;
         end
         WAIT: if (cnt_q == '0) begin
            error_d = err;
            rdata_d = (err || write_q) ? 32'h0 : rdata_ext;
            state_d = RESP;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
         RESP: if (bus.resp_ready) begin
            rdata_d = 32'h0;
            error_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and response state, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         write_q  <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         funct3_q <= 3'h0;
         rdata_q  <= 32'h0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         rdata_q  <= rdata_d;
         error_q  <= error_d;
      end
   end

   // Storage array: byte-lane writes, contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[addr_q[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

`ifdef DATA_MEMORY_STATS_EN
   logic [15:0] loads_q, stores_q, errors_q;

   assign stat_loads  = loads_q;
   assign stat_stores = stores_q;
   assign stat_errors = errors_q;

   // Saturating event counters, bumped on the access edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         loads_q  <= 16'h0;
         stores_q <= 16'h0;
         errors_q <= 16'h0;
      end else if (access) begin
         if (err) begin
            if (errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
         end else if (write_q) begin
            if (stores_q != 16'hFFFF) stores_q <= stores_q + 16'd1;
         end else begin
            if (loads_q != 16'hFFFF) loads_q <= loads_q + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_data_memory;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   data_memory_if bif ();

`ifdef DATA_MEMORY_STATS_EN
   logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

   data_memory #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
`ifdef DATA_MEMORY_STATS_EN
      ,
      .stat_loads  (stat_loads),
      .stat_stores (stat_stores),
      .stat_errors (stat_errors)
`endif
   );

   // Issue one request and wait for resp_valid; resp_ready stays low.
   // lat = edges from the accept edge to resp_valid seen high.
   task automatic txn(input logic w, input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] f3, output logic [31:0] rdata,
                      output logic err, output int lat);
      int n;
      rdata = 32'h0; err = 1'b0; lat = 0;
      @(negedge clk);
      bif.req_valid  = 1'b1;
      bif.req_write  = w;
      bif.req_addr   = addr;
      bif.req_wdata  = data;
      bif.req_funct3 = f3;
      bif.resp_ready = 1'b0;
      n = 0;
      while (!bif.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bif.req_ready) begin
         n_tests++; n_fail++;
         $display("FAIL req_accept_timeout: req_ready=%b required 1", bif.req_ready);
         bif.req_valid = 1'b0;
         lat = 99;
         return;
      end
      @(posedge clk);
      #1 bif.req_valid = 1'b0;
      while (lat < 50) begin
         if (lat > 0) begin
            @(posedge clk);
            #1;
         end else begin
            @(posedge clk);
            #1;
         end
         lat++;
         if (bif.resp_valid) break;
      end
      if (!bif.resp_valid) begin
         n_tests++; n_fail++;
         $display("FAIL resp_timeout: resp_valid=%b required 1", bif.resp_valid);
         lat = 99;
      end
      rdata = bif.resp_rdata;
      err   = bif.resp_error;
   endtask

   task automatic ack();
      @(negedge clk);
      bif.resp_ready = 1'b1;
      @(posedge clk);
      #1 bif.resp_ready = 1'b0;
   endtask

   task automatic access(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] f3, output logic [31:0] rdata,
                         output logic err, output int lat);
      txn(w, addr, data, f3, rdata, err, lat);
      ack();
   endtask

   task automatic test_reset();
      #2;
      n_tests += 4;
      if (bif.req_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", bif.req_ready); end
      if (bif.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bif.resp_valid); end
      if (bif.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bif.resp_rdata); end
      if (bif.resp_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", bif.resp_error); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bif.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready: got %b want 1", bif.req_ready); end
   endtask

   task automatic test_word();
      logic [31:0] rd; logic er; int lat;
      access(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, rd, er, lat);
      n_tests += 3;
      if (er !== 1'b0)   begin n_fail++; $display("FAIL sw_err: got %b want 0", er); end
      if (rd !== 32'h0)  begin n_fail++; $display("FAIL sw_rdata: got %h want 0", rd); end
      if (lat != 3)      begin n_fail++; $display("FAIL sw_latency: got %0d want 3", lat); end
      access(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
      n_tests += 3;
      if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
      if (er !== 1'b0)   begin n_fail++; $display("FAIL lw_err: got %b want 0", er); end
      if (lat != 3)      begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
   endtask

   task automatic test_sub_word();
      logic [31:0] rd; logic er; int lat;
      logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
      logic [2:0]  f3s   [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
      logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
      for (int i = 0; i < 4; i++) begin
         access(1'b0, addrs[i], 32'h0, f3s[i], rd, er, lat);
         n_tests += 2;
         if (rd !== exps[i]) begin n_fail++; $display("FAIL subword_%0d_rdata: got %h want %h", i, rd, exps[i]); end
         if (er !== 1'b0)    begin n_fail++; $display("FAIL subword_%0d_err: got %b want 0", i, er); end
      end
   endtask

   task automatic test_byte_store();
      logic [31:0] rd; logic er; int lat;
      access(1'b1, 32'h11, 32'h12345677, 3'd0, rd, er, lat);
      n_tests++;
      if (er !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b want 0", er); end
      access(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
      n_tests++;
      if (rd !== 32'hDEAD77EF) begin n_fail++; $display("FAIL sb_lane: got %h want dead77ef", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat;
      logic        ws    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] addrs [5] = '{32'h12, 32'h400, 32'h10, 32'h10, 32'h11};
      logic [2:0]  f3s   [5] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd1};
      for (int i = 0; i < 5; i++) begin
         access(ws[i], addrs[i], 32'hFFFFFFFF, f3s[i], rd, er, lat);
         n_tests += 2;
         if (er !== 1'b1)   begin n_fail++; $display("FAIL err_%0d_flag: got %b want 1", i, er); end
         if (rd !== 32'h0)  begin n_fail++; $display("FAIL err_%0d_rdata: got %h want 0", i, rd); end
      end
      access(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
      n_tests++;
      if (rd !== 32'hDEAD77EF) begin n_fail++; $display("FAIL err_mem_unchanged: got %h want dead77ef", rd); end
      // Last word in range is legal
      access(1'b1, 32'h3FC, 32'hA5A51234, 3'd2, rd, er, lat);
      n_tests++;
      if (er !== 1'b0) begin n_fail++; $display("FAIL top_word_sw_err: got %b want 0", er); end
      access(1'b0, 32'h3FC, 32'h0, 3'd2, rd, er, lat);
      n_tests += 2;
      if (er !== 1'b0)         begin n_fail++; $display("FAIL top_word_lw_err: got %b want 0", er); end
      if (rd !== 32'hA5A51234) begin n_fail++; $display("FAIL top_word_lw_rdata: got %h want a5a51234", rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er; int lat;
      txn(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_tests += 3;
         if (bif.resp_valid !== 1'b1)        begin n_fail++; $display("FAIL hold_%0d_valid: got %b want 1", i, bif.resp_valid); end
         if (bif.resp_rdata !== 32'hDEAD77EF) begin n_fail++; $display("FAIL hold_%0d_rdata: got %h want dead77ef", i, bif.resp_rdata); end
         if (bif.req_ready !== 1'b0)         begin n_fail++; $display("FAIL hold_%0d_req_ready: got %b want 0", i, bif.req_ready); end
      end
      ack();
      n_tests += 3;
      if (bif.resp_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", bif.resp_valid); end
      if (bif.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL release_rdata: got %h want 0", bif.resp_rdata); end
      if (bif.req_ready !== 1'b1)  begin n_fail++; $display("FAIL release_req_ready: got %b want 1", bif.req_ready); end
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] rd; logic er; int lat;
      access(1'b1, 32'h20, 32'h0, 3'd2, rd, er, lat);
`ifdef DATA_MEMORY_STATS_EN
      n_tests += 3;
      if (stat_loads !== 16'd9)  begin n_fail++; $display("FAIL stat_loads: got %0d want 9", stat_loads); end
      if (stat_stores !== 16'd4) begin n_fail++; $display("FAIL stat_stores: got %0d want 4", stat_stores); end
      if (stat_errors !== 16'd5) begin n_fail++; $display("FAIL stat_errors: got %0d want 5", stat_errors); end
`endif
      @(negedge clk);
      bif.req_valid  = 1'b1;
      bif.req_write  = 1'b1;
      bif.req_addr   = 32'h20;
      bif.req_wdata  = 32'h1;
      bif.req_funct3 = 3'd2;
      @(posedge clk);
      #1 bif.req_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      n_tests += 3;
      if (bif.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bif.resp_valid); end
      if (bif.req_ready !== 1'b0)  begin n_fail++; $display("FAIL midrst_req_ready: got %b want 0", bif.req_ready); end
      if (bif.resp_error !== 1'b0) begin n_fail++; $display("FAIL midrst_error: got %b want 0", bif.resp_error); end
`ifdef DATA_MEMORY_STATS_EN
      n_tests++;
      if ({stat_loads, stat_stores, stat_errors} !== 48'h0) begin
         n_fail++; $display("FAIL midrst_stats: got %h want 0", {stat_loads, stat_stores, stat_errors});
      end
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      access(1'b0, 32'h20, 32'h0, 3'd2, rd, er, lat);
      n_tests += 2;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_no_write: got %h want 0", rd); end
      if (er !== 1'b0)  begin n_fail++; $display("FAIL midrst_lw_err: got %b want 0", er); end
   endtask

   initial begin
      bif.req_valid  = 1'b0;
      bif.req_write  = 1'b0;
      bif.req_addr   = 32'h0;
      bif.req_wdata  = 32'h0;
      bif.req_funct3 = 3'd0;
      bif.resp_ready = 1'b0;
      test_reset();
      test_word();
      test_sub_word();
      test_byte_store();
      test_errors();
      test_backpressure();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
